// File: rtl/somador_serial_if.sv
// Request/result bundle for somador_serial.
// When SOMADOR_SERIAL_OVF_EN is defined, the bundle also carries the ovf signed-overflow flag.
interface somador_serial_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             ci;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] soma;
    logic             co;
`ifdef SOMADOR_SERIAL_OVF_EN
    logic             ovf;
`endif

    modport master (
        output start, a, b, sub, ci,
`ifdef SOMADOR_SERIAL_OVF_EN
        input  ovf,
`endif
        input  busy, done, soma, co
    );

    modport slave (
        input  start, a, b, sub, ci,
`ifdef SOMADOR_SERIAL_OVF_EN
        output ovf,
`endif
        output busy, done, soma, co
    );
endinterface

// File: rtl/somador_serial.sv
// Multi-cycle serial adder/subtractor: LSB-first, DIGIT bits per clock through one adder slice.
// Optional SOMADOR_SERIAL_OVF_EN adds a registered two's-complement overflow flag (ovf).
module somador_serial_fa (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = x ^ y ^ cin;
    assign cout = (x & y) | (cin & (x ^ y));
endmodule

module somador_serial #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    somador_serial_if.slave bus
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [WIDTH-1:0] nres;
    logic [DIGIT-1:0] sum;
    logic [DIGIT:0]   cc;
    logic             carry;
    logic [CW-1:0]    cnt;

    // Ripple slice; cc[DIGIT-1] is the carry into the slice MSB, which on the
    // last digit is the carry into the word MSB (used for signed overflow).
    assign cc[0] = carry;
    for (genvar i = 0; i < DIGIT; i++) begin : g_slice
        somador_serial_fa u_fa (
            .x    (ra[i]),
            .y    (rb[i]),
            .cin  (cc[i]),
            .s    (sum[i]),
            .cout (cc[i+1])
        );
    end

    // Partial result fills from the top; the newest digit lands in the MSBs.
    if (DIGIT == WIDTH) begin : g_one
        assign nres = sum;
    end else begin : g_multi
        logic [WIDTH-DIGIT-1:0] rres;
        assign nres = {sum, rres};
        always_ff @(posedge clk) begin
            if (!rst_n)
                rres <= '0;
            else if (state == CALC)
                rres <= nres[WIDTH-1:DIGIT];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            ra       <= '0;
            rb       <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.soma <= '0;
            bus.co   <= 1'b0;
`ifdef SOMADOR_SERIAL_OVF_EN
            bus.ovf  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        ra       <= bus.a;
                        rb       <= bus.sub ? ~bus.b : bus.b;
                        carry    <= bus.sub | bus.ci;
                        cnt      <= '0;
                        bus.busy <= 1'b1;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    ra    <= ra >> DIGIT;
                    rb    <= rb >> DIGIT;
                    carry <= cc[DIGIT];
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        bus.soma <= nres;
                        bus.co   <= cc[DIGIT];
`ifdef SOMADOR_SERIAL_OVF_EN
                        bus.ovf  <= cc[DIGIT] ^ cc[DIGIT-1];
`endif
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    bus.done <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    bus.busy <= 1'b0;
                    bus.done <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_somador_serial.sv
// Directed bench for somador_serial: three instances (DIGIT = 1, 4, 2) on a shared clock/reset.
module tb_somador_serial;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   ncmp = 0;
    int   nerr = 0;

    always #5 clk = ~clk;

    somador_serial_if #(.WIDTH(8)) i1 ();
    somador_serial_if #(.WIDTH(8)) i4 ();
    somador_serial_if #(.WIDTH(8)) i2 ();

    somador_serial #(.WIDTH(8), .DIGIT(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(i1));
    somador_serial #(.WIDTH(8), .DIGIT(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(i4));
    somador_serial #(.WIDTH(8), .DIGIT(2)) u2 (.clk(clk), .rst_n(rst_n), .bus(i2));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present an operation to the DIGIT=1 instance and take the accept edge.
    task automatic go1(input logic [7:0] a, input logic [7:0] b, input logic s, input logic c);
        i1.a = a; i1.b = b; i1.sub = s; i1.ci = c; i1.start = 1'b1;
        tick();
        i1.start = 1'b0;
    endtask

    initial begin
        int pulses;
        i1.start = 0; i1.a = 0; i1.b = 0; i1.sub = 0; i1.ci = 0;
        i4.start = 0; i4.a = 0; i4.b = 0; i4.sub = 0; i4.ci = 0;
        i2.start = 0; i2.a = 0; i2.b = 0; i2.sub = 0; i2.ci = 0;
        tick();
        tick();
        rst_n = 1'b1;

        chk("rst_busy", i1.busy, 1'b0);
        chk("rst_done", i1.done, 1'b0);
        chk("rst_soma", i1.soma, 8'h00);
        chk("rst_co", i1.co, 1'b0);
        chk("rst_soma4", i4.soma, 8'h00);

        // 0xFF + 0x01: busy for 8 cycles, done after the 9th edge
        go1(8'hFF, 8'h01, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            chk("t1_busy", i1.busy, 1'b1);
            chk("t1_nodone", i1.done, 1'b0);
            tick();
        end
        chk("t1_done", i1.done, 1'b1);
        chk("t1_busy_lo", i1.busy, 1'b0);
        chk("t1_soma", i1.soma, 8'h00);
        chk("t1_co", i1.co, 1'b1);
`ifdef SOMADOR_SERIAL_OVF_EN
        chk("t1_ovf", i1.ovf, 1'b0);
`endif
        tick();
        chk("t1_pulse", i1.done, 1'b0);

        // 5 - 7 = 0xFE with borrow; soma holds old value during CALC
        go1(8'h05, 8'h07, 1'b1, 1'b0);
        repeat (4) tick();
        chk("t2_hold", i1.soma, 8'h00);
        repeat (4) tick();
        chk("t2a_done", i1.done, 1'b1);
        chk("t2a_soma", i1.soma, 8'hFE);
        chk("t2a_co", i1.co, 1'b0);
        tick();
        go1(8'h07, 8'h05, 1'b1, 1'b1);
        repeat (8) tick();
        chk("t2b_done", i1.done, 1'b1);
        chk("t2b_soma", i1.soma, 8'h02);
        chk("t2b_co", i1.co, 1'b1);
        tick();

        // DIGIT=4: 0x3C + 0x4D + 1 = 0x8A, signed overflow
        i4.a = 8'h3C; i4.b = 8'h4D; i4.sub = 1'b0; i4.ci = 1'b1; i4.start = 1'b1;
        tick();
        i4.start = 1'b0;
        chk("t3_busy0", i4.busy, 1'b1);
        tick();
        chk("t3_busy1", i4.busy, 1'b1);
        chk("t3_nodone", i4.done, 1'b0);
        tick();
        chk("t3_done", i4.done, 1'b1);
        chk("t3_soma", i4.soma, 8'h8A);
        chk("t3_co", i4.co, 1'b0);
`ifdef SOMADOR_SERIAL_OVF_EN
        chk("t3_ovf", i4.ovf, 1'b1);
`endif
        tick();

        // second start mid-CALC must be ignored
        go1(8'h10, 8'h20, 1'b0, 1'b0);
        repeat (2) tick();
        i1.a = 8'hAA; i1.b = 8'h55; i1.start = 1'b1;
        tick();
        i1.start = 1'b0;
        repeat (4) tick();
        chk("t4_nodone", i1.done, 1'b0);
        tick();
        chk("t4_done", i1.done, 1'b1);
        chk("t4_soma", i1.soma, 8'h30);
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (i1.done) pulses++;
        end
        chk("t4_onepulse", pulses, 0);

        // reset at counter=3 abandons the operation
        go1(8'h40, 8'h40, 1'b0, 1'b0);
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("t5_busy", i1.busy, 1'b0);
        chk("t5_soma", i1.soma, 8'h00);
        chk("t5_co", i1.co, 1'b0);
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            if (i1.done) pulses++;
            tick();
        end
        chk("t5_nodone", pulses, 0);
        go1(8'h01, 8'h01, 1'b0, 1'b0);
        repeat (7) tick();
        chk("t5_early", i1.done, 1'b0);
        tick();
        chk("t5_done", i1.done, 1'b1);
        chk("t5_soma2", i1.soma, 8'h02);
        tick();

        // DIGIT=2, start held: done every 6 cycles
        i2.a = 8'h01; i2.b = 8'h01; i2.sub = 1'b0; i2.ci = 1'b0; i2.start = 1'b1;
        pulses = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            chk("t6_done", i2.done, ((k % 6) == 4) ? 1'b1 : 1'b0);
            if (i2.done) begin
                pulses++;
                chk("t6_soma", i2.soma, 8'h02);
            end
        end
        i2.start = 1'b0;
        chk("t6_pulses", pulses, 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
